conv_psum_accumulator: RTL and testbench

//  Downstream of the convolution PE column. Collects the 32-bit outpsum stream over
//  NUM_PASSES passes, one pass per filter row / input channel slice. Accumulates it
//  per output position into a DEPTH-entry buffer. After the last pass, streams the

---
 rtl/conv_psum_accumulator.sv | 145 ++++++++++++++
 tb/tb_conv_psum_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_accumulator.sv
// Partial-sum accumulator for the convolution PE column.
// Sums the psum stream over NUM_PASSES passes into a DEPTH-entry buffer,
// then streams the finished ofmap values out over a valid/ready handshake.
module conv_psum_accumulator #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_PASSES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     idx;
  logic [PW-1:0]     pass;
  logic [DATA_W-1:0] psum_buf [DEPTH];

  logic              accept;
  logic              out_fire;
  logic              idx_last;
  logic              pass_last;
  logic [DATA_W:0]   sum_ext;

  assign accept    = psum_valid & psum_ready;
  assign out_fire  = out_valid & out_ready;
  assign idx_last  = (idx == IDX_LAST);
  assign pass_last = (pass == PASS_LAST);
  assign sum_ext   = {1'b0, psum_buf[idx]} + {1'b0, psum_in};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (accept && idx_last && pass_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_fire && idx_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; out_data reads the buffer combinationally so it holds while stalled
  always_comb begin
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    unique case (state)
      IDLE: ;
      ACCUM: psum_ready = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = psum_buf[idx];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Position/pass counters and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      pass     <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            pass     <= '0;
            overflow <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (pass != '0 && sum_ext[DATA_W]) overflow <= 1'b1;
            if (idx_last) begin
              idx  <= '0;
              pass <= pass_last ? '0 : pass + 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) idx <= idx_last ? '0 : idx + 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  // Accumulation buffer: first pass overwrites, later passes add modulo 2^DATA_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) psum_buf[i] <= '0;
    end else if (accept) begin
      psum_buf[idx] <= (pass == '0) ? psum_in : sum_ext[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Randomized self-checking bench for conv_psum_accumulator (DEPTH=4, NUM_PASSES=3).
module tb_conv_psum_accumulator;

  localparam int D = 4;
  localparam int P = 3;
  localparam int N = D * P;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] psum_in;
  logic        psum_valid;
  logic        psum_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] vals [N];

  conv_psum_accumulator #(
    .DATA_W     (32),
    .DEPTH      (D),
    .NUM_PASSES (P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_psum_ready"}, psum_ready, 1'b0);
    check_eq({tag, "_out_valid"},  out_valid,  1'b0);
    check_eq({tag, "_out_data"},   out_data,   32'h0);
    check_eq({tag, "_busy"},       busy,       1'b0);
    check_eq({tag, "_done"},       done,       1'b0);
    check_eq({tag, "_overflow"},   overflow,   1'b0);
  endtask

  // Pulse start in IDLE together with a psum that must not be consumed
  task automatic start_tile();
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_psum_ready", psum_ready, 1'b0);
    start      = 1'b1;
    psum_valid = 1'b1;
    psum_in    = $urandom;
    @(negedge clk);
    start      = 1'b0;
    psum_valid = 1'b0;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_ovf_clear", overflow, 1'b0);
    check_eq("accum_psum_ready", psum_ready, 1'b1);
  endtask

  // Present one psum; returns with it driven so the next rising edge accepts it
  task automatic feed(input logic [31:0] v, input bit rv, input bit sn);
    int unsigned g;
    g = 0;
    @(negedge clk);
    if (sn) start = 1'($urandom_range(0, 1));
    while (rv && $urandom_range(0, 2) == 0 && g < 20) begin
      psum_valid = 1'b0;
      psum_in    = $urandom;
      check_eq("accum_ready_gap", psum_ready, 1'b1);
      @(negedge clk);
      if (sn) start = 1'($urandom_range(0, 1));
      g++;
    end
    psum_valid = 1'b1;
    psum_in    = v;
    check_eq("accum_ready", psum_ready, 1'b1);
  endtask

  // Full tile from the vals[] table (pass-major), checked against plain summation
  task automatic run_tile(input bit rv, input bit rr, input bit stall, input bit sn);
    logic [31:0]     expq [D];
    bit              exp_ov;
    longint unsigned s;
    int unsigned     k;
    int unsigned     guard;
    int unsigned     stall_cnt;
    exp_ov = 1'b0;
    for (int i = 0; i < D; i++) begin
      s = 0;
      for (int p = 0; p < P; p++) s += 64'(vals[p * D + i]);
      expq[i] = s[31:0];
      if (s > 64'hFFFF_FFFF) exp_ov = 1'b1;
    end

    start_tile();
    for (int n = 0; n < N; n++) feed(vals[n], rv, sn);

    @(negedge clk);
    psum_valid = 1'b0;
    start      = 1'b0;
    check_eq("latency_out_valid", out_valid, 1'b1);

    k         = 0;
    guard     = 0;
    stall_cnt = 0;
    while (k < D && guard < 200) begin
      check_eq("drain_psum_ready", psum_ready, 1'b0);
      check_eq("drain_out_valid", out_valid, 1'b1);
      if (stall && k == 1 && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sn) start = 1'($urandom_range(0, 1));
      if (out_ready) begin
        check_eq("out_data", out_data, expq[k]);
        k++;
      end else begin
        check_eq("out_data_stall", out_data, expq[k]);
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    if (guard >= 200) check_eq("drain_timeout", 1'b0, 1'b1);

    check_eq("done_pulse", done, 1'b1);
    check_eq("done_out_valid", out_valid, 1'b0);
    check_eq("done_psum_ready", psum_ready, 1'b0);
    check_eq("done_overflow", overflow, exp_ov);
    @(negedge clk);
    check_eq("done_clear", done, 1'b0);
    check_eq("idle_after_busy", busy, 1'b0);
    check_eq("idle_overflow_sticky", overflow, exp_ov);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    psum_in    = '0;
    psum_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Ramp pattern: 6, 12, 18, 24
    for (int p = 0; p < P; p++)
      for (int i = 0; i < D; i++) vals[p * D + i] = 32'((i + 1) * (p + 1));
    run_tile(1'b0, 1'b0, 1'b0, 1'b0);
    run_tile(1'b0, 1'b0, 1'b1, 1'b0);
    run_tile(1'b1, 1'b1, 1'b0, 1'b0);

    // Wrap at position 1: FFFF_FFFF + 2 = 1 with overflow
    for (int n = 0; n < N; n++) vals[n] = $urandom_range(0, 1000);
    vals[1]     = 32'hFFFF_FFFF;
    vals[D + 1] = 32'h2;
    vals[2*D+1] = 32'h0;
    run_tile(1'b1, 1'b0, 1'b0, 1'b0);

    // Start pulses during ACCUM/DRAIN; this tile also checks overflow was cleared
    for (int n = 0; n < N; n++) vals[n] = $urandom_range(0, 100000);
    run_tile(1'b1, 1'b1, 1'b0, 1'b1);

    // Reset in pass 1 at idx 2 with overflow already raised
    for (int n = 0; n < N; n++) vals[n] = $urandom_range(0, 1000);
    vals[0] = 32'hFFFF_FFF0;
    vals[D] = 32'h20;
    start_tile();
    for (int n = 0; n < D + 2; n++) feed(vals[n], 1'b0, 1'b0);
    @(negedge clk);
    psum_valid = 1'b0;
    check_eq("pre_reset_overflow", overflow, 1'b1);
    check_eq("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < N; n++) vals[n] = $urandom_range(0, 50);
    run_tile(1'b0, 1'b0, 1'b0, 1'b0);

    // Full-range random tiles
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < N; n++) vals[n] = $urandom;
      run_tile(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
